branch_resolver: RTL

Parametrised successor to the CPU branch controller. Decodes the 5-bit opcode field of the incoming instruction and computes a registered branch target with a valid/taken handshake. Owns an internal return-address stack (RAS) with configurable depth and overflow policy, plus sticky overflow/underflow fault flags. Sits between decode and the fetch PC mux.

---
 rtl/branch_resolver.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/branch_resolver.sv
// branch_resolver: decodes branch-class opcodes into a registered fetch target and owns a return-address stack.
// Ports: clk/rst (async, active-low); instr_valid/instr/rd/immediate/ret_addr/flag in;
// fault_clr clears sticky faults; target/target_valid/taken out; full/empty/stack_count
// report RAS occupancy; overflow/underflow are sticky fault flags.
module branch_resolver #(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 15,
    parameter int DEPTH     = 32,
    parameter int WRAP_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       instr_valid,
    input  logic [DWIDTH-1:0]          instr,
    input  logic [DWIDTH-1:0]          rd,
    input  logic [DWIDTH-1:0]          immediate,
    input  logic [AWIDTH-1:0]          ret_addr,
    input  logic                       flag,
    input  logic                       fault_clr,
    output logic [DWIDTH-1:0]          target,
    output logic                       target_valid,
    output logic                       taken,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] stack_count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [4:0] OP_JR   = 5'b01101;
    localparam logic [4:0] OP_JPC  = 5'b01110;
    localparam logic [4:0] OP_BRFL = 5'b01111;
    localparam logic [4:0] OP_CALL = 5'b10000;
    localparam logic [4:0] OP_RET  = 5'b10001;

    logic [AWIDTH-1:0] ras_q [DEPTH];
    // ptr_q is the next free slot; the top entry lives at ptr_q-1 (mod DEPTH)
    logic [PW-1:0]     ptr_q, ptr_d, ptr_inc, ptr_dec;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DWIDTH-1:0] target_q, target_d;
    logic              valid_q, valid_d, taken_q, taken_d;
    logic              ovf_q, ovf_d, unf_q, unf_d, ovf_set, unf_set, push;
    logic              is_full, is_empty;
    logic [4:0]        op;
    logic              unused_instr;

    assign op           = instr[DWIDTH-1 -: 5];
    assign unused_instr = ^instr[DWIDTH-6:0];
    assign is_full      = cnt_q == CW'(DEPTH);
    assign is_empty     = cnt_q == '0;
    assign ptr_inc      = (ptr_q == PW'(DEPTH-1)) ? '0 : ptr_q + 1'b1;
    assign ptr_dec      = (ptr_q == '0) ? PW'(DEPTH-1) : ptr_q - 1'b1;

    always_comb begin
        target_d = target_q;
        valid_d  = 1'b0;
        taken_d  = 1'b0;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        push     = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        if (instr_valid) begin
            case (op)
                OP_JR: begin
                    target_d = rd;
                    valid_d  = 1'b1;
                    taken_d  = 1'b1;
                end
                OP_JPC: begin
                    target_d = immediate + rd + DWIDTH'(1);
                    valid_d  = 1'b1;
                    taken_d  = 1'b1;
                end
                OP_BRFL: begin
                    target_d = rd;
                    valid_d  = 1'b1;
                    taken_d  = flag;
                end
                OP_CALL: begin
                    target_d = rd;
                    valid_d  = 1'b1;
                    taken_d  = 1'b1;
                    // in circular mode a push while full overwrites the oldest slot,
                    // which is exactly the next free slot once the ring has wrapped
                    if (!is_full || WRAP_MODE != 0) begin
                        push  = 1'b1;
                        ptr_d = ptr_inc;
                        cnt_d = is_full ? cnt_q : cnt_q + 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
                OP_RET: begin
                    valid_d = 1'b1;
                    if (is_empty) begin
                        target_d = '0;
                        unf_set  = 1'b1;
                    end else begin
                        target_d = DWIDTH'(ras_q[ptr_dec]);
                        taken_d  = 1'b1;
                        ptr_d    = ptr_dec;
                        cnt_d    = cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
        ovf_d = ovf_set | (ovf_q & ~fault_clr);
        unf_d = unf_set | (unf_q & ~fault_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target_q <= '0;
            valid_q  <= 1'b0;
            taken_q  <= 1'b0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            valid_q  <= valid_d;
            taken_q  <= taken_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // stack storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (push) ras_q[ptr_q] <= ret_addr;
    end

    assign target       = target_q;
    assign target_valid = valid_q;
    assign taken        = taken_q;
    assign full         = is_full;
    assign empty        = is_empty;
    assign stack_count  = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
endmodule
